hazard_flush_controller: RTL and testbench

//  Parametrised pipeline hazard/flush controller, successor of the fixed 5-stage Controller.

---
 rtl/kirameki_ctrl_pkg.sv | 18 +
 rtl/fwd_select.sv | 37 +++
 rtl/hazard_flush_controller.sv | 148 ++++++++++++++
 tb/tb_hazard_flush_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kirameki_ctrl_pkg.sv
// Shared encodings for the hazard/flush controller:
// per-stage control codes, controller states, register address width.
package kirameki_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SC_RUN   = 2'b00,
    SC_STALL = 2'b01,
    SC_FLUSH = 2'b10
  } StageCtrl;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } CtrlState;

endpackage

// File: rtl/fwd_select.sv
// Operand bypass selector: youngest matching writer wins,
// a match whose value is not ready yet falls back to RF data.
module fwd_select
  import kirameki_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2
) (
  input  logic [REG_ADDR_W-1:0]           rs_addr_i,
  input  logic                            use_rs_i,
  input  logic [XLEN-1:0]                 rf_data_i,
  input  logic [FWD_DEPTH-1:0]            fwd_valid_i,
  input  logic [FWD_DEPTH-1:0]            fwd_ready_i,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] fwd_addr_i,
  input  logic [FWD_DEPTH*XLEN-1:0]       fwd_data_i,
  output logic [XLEN-1:0]                 data_o,
  output logic                            not_ready_o
);

  logic hit;

  always_comb begin
    data_o      = rf_data_i;
    not_ready_o = 1'b0;
    hit         = 1'b0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      if (!hit && fwd_valid_i[i] && rs_addr_i != '0 &&
          fwd_addr_i[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i) begin
        hit         = 1'b1;
        not_ready_o = use_rs_i & ~fwd_ready_i[i];
        if (fwd_ready_i[i]) data_o = fwd_data_i[i*XLEN +: XLEN];
      end
    end
    if (rs_addr_i == '0) data_o = '0;
  end

endmodule

// File: rtl/hazard_flush_controller.sv
// Pipeline hazard/flush controller: bypass, stage RUN/STALL/FLUSH,
// branch redirect handshake and saturating stall/flush counters.
module hazard_flush_controller
  import kirameki_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_STAGES    = 5,
  parameter int FWD_DEPTH     = 2,
  parameter int RESOLVE_STAGE = 2,
  parameter int STRUCT_STAGE  = 2,
  parameter int CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [REG_ADDR_W-1:0]           rs1Addr,
  input  logic [REG_ADDR_W-1:0]           rs2Addr,
  input  logic                            useRs1,
  input  logic                            useRs2,
  input  logic [XLEN-1:0]                 rfRs1,
  input  logic [XLEN-1:0]                 rfRs2,
  input  logic [FWD_DEPTH-1:0]            fwdValid,
  input  logic [FWD_DEPTH-1:0]            fwdReady,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] fwdAddr,
  input  logic [FWD_DEPTH*XLEN-1:0]       fwdData,
  input  logic                            mulDivBusy,
  input  logic                            resValid,
  input  logic                            resTaken,
  input  logic                            resPredTaken,
  input  logic [XLEN-1:0]                 resTarget,
  input  logic [XLEN-1:0]                 resPredTarget,
  input  logic                            redirectReady,
  output logic [XLEN-1:0]                 bypassedRs1,
  output logic [XLEN-1:0]                 bypassedRs2,
  output logic [NUM_STAGES*2-1:0]         stageCtrl,
  output logic                            redirectValid,
  output logic [XLEN-1:0]                 redirectPc,
  output logic                            mulDivClear,
  output logic [CNT_W-1:0]                stallCnt,
  output logic [CNT_W-1:0]                flushCnt
);

  CtrlState         state_q, state_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             haz1, haz2, data_haz, miss, any_stall;

  fwd_select #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs1 (
    .rs_addr_i  (rs1Addr),
    .use_rs_i   (useRs1),
    .rf_data_i  (rfRs1),
    .fwd_valid_i(fwdValid),
    .fwd_ready_i(fwdReady),
    .fwd_addr_i (fwdAddr),
    .fwd_data_i (fwdData),
    .data_o     (bypassedRs1),
    .not_ready_o(haz1)
  );

  fwd_select #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs2 (
    .rs_addr_i  (rs2Addr),
    .use_rs_i   (useRs2),
    .rf_data_i  (rfRs2),
    .fwd_valid_i(fwdValid),
    .fwd_ready_i(fwdReady),
    .fwd_addr_i (fwdAddr),
    .fwd_data_i (fwdData),
    .data_o     (bypassedRs2),
    .not_ready_o(haz2)
  );

  assign data_haz = haz1 | haz2;
  assign miss = (state_q == ST_RUN) && resValid &&
                ((resTaken != resPredTaken) ||
                 (resTarget != resPredTarget));

  // priority: miss > redirect pending > mul/div busy > load-use
  always_comb begin
    stageCtrl   = '0;
    mulDivClear = 1'b0;
    if (miss) begin
      mulDivClear = (STRUCT_STAGE < RESOLVE_STAGE);
      for (int i = 0; i < NUM_STAGES; i++)
        if (i < RESOLVE_STAGE) stageCtrl[2*i +: 2] = SC_FLUSH;
    end else if (state_q == ST_REDIRECT) begin
      stageCtrl[1:0] = SC_STALL;
      for (int i = 1; i < NUM_STAGES; i++)
        if (i < RESOLVE_STAGE) stageCtrl[2*i +: 2] = SC_FLUSH;
    end else if (mulDivBusy) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i <= STRUCT_STAGE) stageCtrl[2*i +: 2] = SC_STALL;
        else if (i == STRUCT_STAGE + 1) stageCtrl[2*i +: 2] = SC_FLUSH;
      end
    end else if (data_haz) begin
      stageCtrl[1:0] = SC_STALL;
      stageCtrl[3:2] = SC_STALL;
      stageCtrl[5:4] = SC_FLUSH;
    end
  end

  always_comb begin
    any_stall = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (stageCtrl[2*i +: 2] == SC_STALL) any_stall = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_cnt_d   = flush_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (miss) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = resTarget;
          if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (redirectReady) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (any_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= ST_RUN;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign redirectValid = (state_q == ST_REDIRECT);
  assign redirectPc    = redirect_pc_q;
  assign stallCnt      = stall_cnt_q;
  assign flushCnt      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Bench for hazard_flush_controller: vector table, directed
// multi-cycle sequences and random traffic against a reference model.
module tb_hazard_flush_controller;

  localparam int FD = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rs1, rs2;
  logic        use1, use2;
  logic [31:0] rf1, rf2;
  logic [1:0]  fv, fr;
  logic [9:0]  fa;
  logic [63:0] fd;
  logic        busy, rv, rt, rpt, rdy;
  logic [31:0] rtg, rptg;

  logic [31:0] byp1 [2];
  logic [31:0] byp2 [2];
  logic [31:0] rpc  [2];
  logic [9:0]  sc   [2];
  logic        rvo  [2];
  logic        mdc  [2];
  logic [15:0] stc  [2];
  logic [15:0] flc  [2];

  hazard_flush_controller #(
    .XLEN(32), .NUM_STAGES(5), .FWD_DEPTH(2),
    .RESOLVE_STAGE(2), .STRUCT_STAGE(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rstN(rstN),
    .rs1Addr(rs1), .rs2Addr(rs2), .useRs1(use1), .useRs2(use2),
    .rfRs1(rf1), .rfRs2(rf2),
    .fwdValid(fv), .fwdReady(fr), .fwdAddr(fa), .fwdData(fd),
    .mulDivBusy(busy), .resValid(rv), .resTaken(rt),
    .resPredTaken(rpt), .resTarget(rtg), .resPredTarget(rptg),
    .redirectReady(rdy),
    .bypassedRs1(byp1[0]), .bypassedRs2(byp2[0]),
    .stageCtrl(sc[0]), .redirectValid(rvo[0]),
    .redirectPc(rpc[0]), .mulDivClear(mdc[0]),
    .stallCnt(stc[0]), .flushCnt(flc[0])
  );

  hazard_flush_controller #(
    .XLEN(32), .NUM_STAGES(5), .FWD_DEPTH(2),
    .RESOLVE_STAGE(3), .STRUCT_STAGE(2), .CNT_W(16)
  ) dut3 (
    .clk(clk), .rstN(rstN),
    .rs1Addr(rs1), .rs2Addr(rs2), .useRs1(use1), .useRs2(use2),
    .rfRs1(rf1), .rfRs2(rf2),
    .fwdValid(fv), .fwdReady(fr), .fwdAddr(fa), .fwdData(fd),
    .mulDivBusy(busy), .resValid(rv), .resTaken(rt),
    .resPredTaken(rpt), .resTarget(rtg), .resPredTarget(rptg),
    .redirectReady(rdy),
    .bypassedRs1(byp1[1]), .bypassedRs2(byp2[1]),
    .stageCtrl(sc[1]), .redirectValid(rvo[1]),
    .redirectPc(rpc[1]), .mulDivClear(mdc[1]),
    .stallCnt(stc[1]), .flushCnt(flc[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model state, one slot per instance
  int          RS [2] = '{2, 3};
  bit          m_redir [2];
  logic [31:0] m_pc [2];
  int          m_stall [2];
  int          m_flush [2];
  bit          p_mis [2];
  bit          p_stall [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_redir[k] = 0; m_pc[k] = '0;
      m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  function automatic logic [31:0] mbyp(input logic [4:0] a,
      input logic [31:0] rf, input logic u, output logic haz);
    haz = 1'b0;
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < FD; i++) begin
      if (fv[i] && fa[i*5 +: 5] == a) begin
        haz = u && !fr[i];
        return fr[i] ? fd[i*32 +: 32] : rf;
      end
    end
    return rf;
  endfunction

  // 0 run, 1 stall, 2 flush per stage, packed two bits per stage
  function automatic logic [9:0] mctrl(input int rs, input bit mis,
      input bit redir, input bit bz, input bit hz);
    int c [5];
    logic [9:0] v;
    for (int i = 0; i < 5; i++) c[i] = 0;
    if (mis) begin
      for (int i = 0; i < rs; i++) c[i] = 2;
    end else if (redir) begin
      c[0] = 1;
      for (int i = 1; i < rs; i++) c[i] = 2;
    end else if (bz) begin
      c[0] = 1; c[1] = 1; c[2] = 1; c[3] = 2;
    end else if (hz) begin
      c[0] = 1; c[1] = 1; c[2] = 2;
    end
    v = '0;
    for (int i = 0; i < 5; i++) v[2*i +: 2] = c[i][1:0];
    return v;
  endfunction

  task automatic check_now(input string tag);
    logic [31:0] e1, e2;
    logic h1, h2;
    logic [9:0] es;
    bit mis;
    e1 = mbyp(rs1, rf1, use1, h1);
    e2 = mbyp(rs2, rf2, use2, h2);
    for (int k = 0; k < 2; k++) begin
      mis = !m_redir[k] && rv && (rt != rpt || rtg != rptg);
      es  = mctrl(RS[k], mis, m_redir[k], busy, h1 | h2);
      chk({tag, "/byp1"}, byp1[k], e1);
      chk({tag, "/byp2"}, byp2[k], e2);
      chk({tag, "/stageCtrl"}, sc[k], es);
      chk({tag, "/redirectValid"}, rvo[k], m_redir[k]);
      chk({tag, "/redirectPc"}, rpc[k], m_pc[k]);
      chk({tag, "/mulDivClear"}, mdc[k], mis && (RS[k] > 2));
      chk({tag, "/stallCnt"}, stc[k], m_stall[k]);
      chk({tag, "/flushCnt"}, flc[k], m_flush[k]);
      p_mis[k]   = mis;
      p_stall[k] = (es[1:0] == 2'b01);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (p_mis[k]) begin
        m_redir[k] = 1;
        m_pc[k]    = rtg;
        if (m_flush[k] < 65535) m_flush[k]++;
      end else if (m_redir[k] && rdy) begin
        m_redir[k] = 0;
      end
      if (p_stall[k] && m_stall[k] < 65535) m_stall[k]++;
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    #4;
    check_now(tag);
    advance();
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; use1 = 0; use2 = 0;
    rf1 = 32'h11; rf2 = 32'h22;
    fv = '0; fr = '0; fa = '0; fd = {32'hBB, 32'hAA};
    busy = 0; rv = 0; rt = 0; rpt = 0;
    rtg = '0; rptg = '0; rdy = 0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [1:0]  fv, fr;
    logic [9:0]  fa;
    logic [9:0]  esc;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{5'd5, 5'd0, 1, 1, 2'b11, 2'b11, {5'd5, 5'd5}, 10'h000, 32'hAA, 32'h0};
    tbl[1] = '{5'd0, 5'd5, 1, 1, 2'b11, 2'b11, {5'd5, 5'd5}, 10'h000, 32'h0, 32'hAA};
    tbl[2] = '{5'd5, 5'd6, 1, 1, 2'b10, 2'b11, {5'd5, 5'd5}, 10'h000, 32'hBB, 32'h22};
    tbl[3] = '{5'd1, 5'd7, 0, 1, 2'b01, 2'b00, {5'd0, 5'd7}, 10'h025, 32'h11, 32'h22};
    tbl[4] = '{5'd1, 5'd7, 0, 0, 2'b01, 2'b00, {5'd0, 5'd7}, 10'h000, 32'h11, 32'h22};
    tbl[5] = '{5'd9, 5'd0, 1, 0, 2'b11, 2'b10, {5'd9, 5'd9}, 10'h025, 32'h11, 32'h0};
    tbl[6] = '{5'd9, 5'd0, 1, 0, 2'b11, 2'b01, {5'd9, 5'd9}, 10'h000, 32'hAA, 32'h0};
    tbl[7] = '{5'd5, 5'd3, 1, 1, 2'b00, 2'b11, {5'd5, 5'd3}, 10'h000, 32'h11, 32'h22};

    idle();
    model_reset();
    #12;
    chk("reset/stageCtrl", sc[0], 10'h000);
    chk("reset/redirectValid", rvo[0], 1'b0);
    chk("reset/redirectPc", rpc[0], 32'h0);
    chk("reset/stallCnt", stc[0], 16'h0);
    chk("reset/flushCnt", flc[0], 16'h0);
    chk("reset/mulDivClear", mdc[0], 1'b0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      idle();
      rs1 = tbl[v].rs1; rs2 = tbl[v].rs2;
      use1 = tbl[v].u1; use2 = tbl[v].u2;
      fv = tbl[v].fv; fr = tbl[v].fr; fa = tbl[v].fa;
      #4;
      chk($sformatf("vec%0d/byp1", v), byp1[0], tbl[v].e1);
      chk($sformatf("vec%0d/byp2", v), byp2[0], tbl[v].e2);
      chk($sformatf("vec%0d/ctrl", v), sc[0], tbl[v].esc);
      chk($sformatf("vec%0d/ctrl3", v), sc[1], tbl[v].esc);
      check_now("vec");
      advance();
    end

    // load-use stall then release
    idle();
    do_reset();
    rs2 = 5'd7; use2 = 1; fv = 2'b01; fr = 2'b00; fa = {5'd0, 5'd7};
    #4;
    chk("t2/stall", sc[0], 10'h025);
    check_now("t2a");
    advance();
    fr = 2'b01;
    #4;
    chk("t2/run", sc[0], 10'h000);
    chk("t2/stallCnt", stc[0], 16'd1);
    check_now("t2b");
    advance();

    // multi-cycle unit busy
    idle();
    busy = 1;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("t3/ctrl", sc[0], 10'h095);
      check_now("t3");
      advance();
    end
    busy = 0;
    #4;
    chk("t3/stallCnt", stc[0], 16'd4);
    check_now("t3end");
    advance();

    // mispredict, fetch not ready for two cycles
    idle();
    rv = 1; rt = 1; rpt = 0; rtg = 32'h100; rptg = 32'h200;
    #4;
    chk("t4/miss_ctrl", sc[0], 10'h00A);
    chk("t4/miss_ctrl3", sc[1], 10'h02A);
    chk("t4/clr", mdc[0], 1'b0);
    chk("t4/clr3", mdc[1], 1'b1);
    check_now("t4miss");
    advance();
    rv = 0;
    for (int i = 0; i < 2; i++) begin
      #4;
      chk("t4/rv", rvo[0], 1'b1);
      chk("t4/pc", rpc[0], 32'h100);
      chk("t4/flushCnt", flc[0], 16'd1);
      chk("t4/ctrl", sc[0], 10'h009);
      chk("t4/ctrl3", sc[1], 10'h029);
      check_now("t4wait");
      advance();
    end
    rdy = 1;
    cycle("t4rdy");
    rdy = 0;
    #4;
    chk("t4/rv_drop", rvo[0], 1'b0);
    chk("t4/run", sc[0], 10'h000);
    check_now("t4end");
    advance();

    // miss beats mul/div busy and load-use
    idle();
    rs2 = 5'd7; use2 = 1; fv = 2'b01; fr = 2'b00; fa = {5'd0, 5'd7};
    busy = 1; rv = 1; rt = 0; rpt = 0;
    rtg = 32'h300; rptg = 32'h304; rdy = 1;
    #4;
    chk("t5/ctrl", sc[0], 10'h00A);
    chk("t5/ctrl3", sc[1], 10'h02A);
    chk("t5/clr3", mdc[1], 1'b1);
    check_now("t5miss");
    advance();
    rv = 0;
    #4;
    chk("t5/pc", rpc[0], 32'h300);
    chk("t5/redir_ctrl", sc[0], 10'h009);
    check_now("t5redir");
    advance();
    #4;
    chk("t5/rv_drop", rvo[0], 1'b0);
    chk("t5/busy_ctrl", sc[0], 10'h095);
    check_now("t5busy");
    advance();

    // asynchronous reset while a redirect is pending
    idle();
    rv = 1; rt = 1; rpt = 1; rtg = 32'h40; rptg = 32'h44;
    cycle("t6miss");
    rv = 0;
    chk("t6/pre_rv", rvo[0], 1'b1);
    #1;
    rstN = 1'b0;
    #1;
    chk("t6/rv", rvo[0], 1'b0);
    chk("t6/rv3", rvo[1], 1'b0);
    chk("t6/pc", rpc[0], 32'h0);
    chk("t6/stallCnt", stc[0], 16'h0);
    chk("t6/flushCnt", flc[0], 16'h0);
    chk("t6/ctrl", sc[0], 10'h000);
    #1;
    rstN = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    for (int n = 0; n < 500; n++) begin
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      use1 = 1'($urandom);
      use2 = 1'($urandom);
      rf1 = $urandom;
      rf2 = $urandom;
      fv = 2'($urandom);
      fr = 2'($urandom);
      fa = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fd = {$urandom, $urandom};
      busy = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 2) == 0);
      rt = 1'($urandom);
      rpt = 1'($urandom);
      rtg = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h104;
      rptg = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h104;
      rdy = 1'($urandom);
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
